vec_mem_sequencer: RTL and testbench

//  Sits between the core MEM stage and the 32-bit data-memory master port. Scalar (32b) loads/stores

---
 rtl/vec_mem_sequencer.sv | 180 ++++++++++++++++++
 tb/tb_vec_mem_sequencer.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/vec_mem_sequencer.sv
// vec_mem_sequencer: MEM-stage front end for the 32b data-memory master.
// Scalar accesses pass straight through; vector accesses are split into
// LANES sequential 32b beats while stall_all freezes the pipeline.
// Optional perf counters are enabled by defining VSEQ_PERF_CNT_EN.
module vec_mem_sequencer #(
   parameter int LANES        = 4,
   parameter int READ_LATENCY = 1
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  req_valid,
   input  logic                  req_write,
   input  logic                  req_vector,
   input  logic [31:0]           req_addr,
   input  logic [32*LANES-1:0]   req_wdata,
   output logic [32*LANES-1:0]   rdata,
   output logic                  rdata_valid,
   output logic                  stall_all,
   output logic [31:0]           dm_addr,
   output logic                  dm_read,
   output logic                  dm_write,
   output logic [31:0]           dm_writedata,
   output logic [3:0]            dm_byteenable,
   input  logic [31:0]           dm_readdata,
   input  logic                  dm_waitrequest,
   output logic [31:0]           perf_vec_ops,
   output logic [31:0]           perf_stall_cyc
);

   localparam int IW = (LANES > 1) ? $clog2(LANES) : 1;
   localparam int CW = $clog2(LANES + 1);
   localparam logic [IW-1:0] LAST_BEAT = IW'(LANES - 1);
   localparam logic [CW-1:0] ALL_RSP   = CW'(LANES);

   typedef enum logic [1:0] {IDLE, BURST, DRAIN, DONE} state_t;

   state_t                        state_q, state_d;
   logic [IW-1:0]                 beat_q, beat_d;
   logic [CW-1:0]                 rsp_q, rsp_d;
   logic [31:0]                   base_q, base_d;
   logic [LANES-1:0][31:0]        wdata_q, wdata_d;
   logic                          write_q, write_d;
   logic [LANES-1:0][31:0]        asm_q, asm_d;
   logic [32*LANES-1:0]           rdata_q, rdata_d;
   logic [READ_LATENCY-1:0]       pipe_q, pipe_d;

   assign dm_byteenable = 4'b1111;

   // Next-state, datapath and memory-port outputs.
   always_comb begin
      state_d      = state_q;
      beat_d       = beat_q;
      rsp_d        = rsp_q;
      base_d       = base_q;
      wdata_d      = wdata_q;
      write_d      = write_q;
      asm_d        = asm_q;
      rdata_d      = rdata_q;
      pipe_d       = pipe_q << 1;
      dm_addr      = 32'h0;
      dm_read      = 1'b0;
      dm_write     = 1'b0;
      dm_writedata = 32'h0;
      stall_all    = 1'b0;
      rdata_valid  = 1'b0;
      rdata        = rdata_q;

      // In-order read responses land in the next free lane.
      if (pipe_q[READ_LATENCY-1]) begin
         asm_d[rsp_q[IW-1:0]] = dm_readdata;
         rsp_d                = rsp_q + CW'(1);
      end

      case (state_q)
         IDLE: begin
            if (req_valid && !req_vector) begin
               dm_addr      = req_addr & 32'hFFFF_FFFC;
               dm_read      = ~req_write;
               dm_write     = req_write;
               dm_writedata = req_wdata[31:0];
               stall_all    = dm_waitrequest;
               rdata        = '0;
               rdata[31:0]  = dm_readdata;
               rdata_valid  = ~req_write & ~dm_waitrequest;
            end else if (req_valid && req_vector) begin
               stall_all = 1'b1;
               base_d    = req_addr & 32'hFFFF_FFFC;
               wdata_d   = req_wdata;
               write_d   = req_write;
               beat_d    = '0;
               rsp_d     = '0;
               state_d   = BURST;
            end
         end
         BURST: begin
            stall_all = 1'b1;
            dm_addr   = base_q + (32'(beat_q) << 2);
            dm_read   = ~write_q;
            dm_write  = write_q;
            if (write_q) dm_writedata = wdata_q[beat_q];
            if (!dm_waitrequest) begin
               pipe_d[0] = ~write_q;
               if (beat_q == LAST_BEAT) begin
                  if (write_q || rsp_d == ALL_RSP) state_d = DONE;
                  else                             state_d = DRAIN;
               end else begin
                  beat_d = beat_q + IW'(1);
               end
            end
         end
         DRAIN: begin
            stall_all = 1'b1;
            if (rsp_d == ALL_RSP) state_d = DONE;
         end
         DONE: begin
            rdata_valid = ~write_q;
            state_d     = IDLE;
         end
         default: state_d = IDLE;
      endcase

      // Publish the assembled vector only once the whole load is in.
      if (state_d == DONE && state_q != DONE && !write_q) rdata_d = asm_d;
   end

   // State and datapath registers; reset aborts any burst in flight.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         beat_q  <= '0;
         rsp_q   <= '0;
         base_q  <= '0;
         wdata_q <= '0;
         write_q <= 1'b0;
         asm_q   <= '0;
         rdata_q <= '0;
         pipe_q  <= '0;
      end else begin
         state_q <= state_d;
         beat_q  <= beat_d;
         rsp_q   <= rsp_d;
         base_q  <= base_d;
         wdata_q <= wdata_d;
         write_q <= write_d;
         asm_q   <= asm_d;
         rdata_q <= rdata_d;
         pipe_q  <= pipe_d;
      end
   end

`ifdef VSEQ_PERF_CNT_EN
   logic [31:0] vec_ops_q, vec_ops_d, stall_cyc_q, stall_cyc_d;

   // Saturating event counters: completed vector ops and stalled cycles.
   always_comb begin
      vec_ops_d   = vec_ops_q;
      stall_cyc_d = stall_cyc_q;
      if (state_q == DONE && vec_ops_q != 32'hFFFF_FFFF) vec_ops_d = vec_ops_q + 32'd1;
      if (stall_all && stall_cyc_q != 32'hFFFF_FFFF)     stall_cyc_d = stall_cyc_q + 32'd1;
   end

   // Counter registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         vec_ops_q   <= '0;
         stall_cyc_q <= '0;
      end else begin
         vec_ops_q   <= vec_ops_d;
         stall_cyc_q <= stall_cyc_d;
      end
   end

   assign perf_vec_ops   = vec_ops_q;
   assign perf_stall_cyc = stall_cyc_q;
`else
   assign perf_vec_ops   = 32'h0;
   assign perf_stall_cyc = 32'h0;
`endif

endmodule

// File: tb/tb_vec_mem_sequencer.sv
// Directed bench for vec_mem_sequencer (LANES=4, READ_LATENCY=2).
// Inputs change at the falling edge; outputs are sampled 1ns later.
module tb_vec_mem_sequencer;
   localparam int RL = 2;

   logic         clk, reset;
   logic         req_valid, req_write, req_vector;
   logic [31:0]  req_addr;
   logic [127:0] req_wdata;
   logic [127:0] rdata;
   logic         rdata_valid, stall_all;
   logic [31:0]  dm_addr, dm_writedata, dm_readdata;
   logic         dm_read, dm_write, dm_waitrequest;
   logic [3:0]   dm_byteenable;
   logic [31:0]  perf_vec_ops, perf_stall_cyc;

   vec_mem_sequencer #(.LANES(4), .READ_LATENCY(RL)) dut (
      .clk(clk), .reset(reset),
      .req_valid(req_valid), .req_write(req_write), .req_vector(req_vector),
      .req_addr(req_addr), .req_wdata(req_wdata),
      .rdata(rdata), .rdata_valid(rdata_valid), .stall_all(stall_all),
      .dm_addr(dm_addr), .dm_read(dm_read), .dm_write(dm_write),
      .dm_writedata(dm_writedata), .dm_byteenable(dm_byteenable),
      .dm_readdata(dm_readdata), .dm_waitrequest(dm_waitrequest),
      .perf_vec_ops(perf_vec_ops), .perf_stall_cyc(perf_stall_cyc)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct { int due; logic [31:0] addr; } rd_t;
   typedef struct { logic [31:0] addr; logic [31:0] data; } wr_t;

   rd_t          rdq[$];
   wr_t          wlog[$];
   logic [31:0]  alog[$];
   int           n_chk = 0, n_fail = 0, cyc_n = 0;
   logic [31:0]  salt = 32'h0;
   logic         s_valid = 0, s_write = 0, s_vector = 0;
   logic [31:0]  s_addr = 0;
   logic [127:0] s_wdata = 0;

   task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] mem_rd(input logic [31:0] a);
      if (a == 32'h100) return 32'hDEADBEEF;
      if (a >= 32'h300 && a < 32'h310) return ((a - 32'h300) >> 2) + 32'd1 + salt;
      return ~a;
   endfunction

   // One clock cycle: apply staged inputs, settle, log memory traffic.
   task automatic step(input logic wr);
      @(negedge clk);
      cyc_n++;
      req_valid = s_valid; req_write = s_write; req_vector = s_vector;
      req_addr = s_addr; req_wdata = s_wdata; dm_waitrequest = wr;
      dm_readdata = 32'h0;
      if (rdq.size() > 0 && rdq[0].due == cyc_n) begin
         dm_readdata = mem_rd(rdq[0].addr);
         void'(rdq.pop_front());
      end else if (s_valid && !s_vector && !s_write) begin
         dm_readdata = mem_rd(s_addr & 32'hFFFF_FFFC);
      end
      #1;
      if (dm_read || dm_write) alog.push_back(dm_addr);
      if (dm_write && !wr) wlog.push_back('{dm_addr, dm_writedata});
      if (dm_read && !wr && stall_all) rdq.push_back('{cyc_n + RL, dm_addr});
   endtask

   // Issue one vector op; waitrequest is held for hold_n cycles on beat hold_beat.
   task automatic run_vec(input logic w, input logic [31:0] a, input logic [127:0] wd,
                          input int hold_beat, input int hold_n,
                          output int stall_n, output int done_n,
                          output logic [127:0] rd, output logic rv);
      int  acc = 0, held = 0;
      logic wr;
      stall_n = 0; done_n = -1; rd = '0; rv = 1'b0;
      wlog.delete(); alog.delete();
      s_valid = 1; s_write = w; s_vector = 1; s_addr = a; s_wdata = wd;
      step(1'b0);
      chk("vec_req_stall", stall_all, 1'b1);
      for (int k = 1; k <= 40; k++) begin
         wr = (acc == hold_beat && held < hold_n);
         step(wr);
         if (dm_read || dm_write) begin
            if (wr) held++;
            else    acc++;
         end
         if (stall_all) stall_n++;
         else begin
            done_n = k; rd = rdata; rv = rdata_valid;
            break;
         end
      end
      if (done_n < 0) chk("vec_timeout", 1'b0, 1'b1);
      s_valid = 0; s_vector = 0; s_write = 0;
   endtask

   int           st_n, dn_n, cnt;
   logic [127:0] rd;
   logic         rv;
   logic [31:0]  exp_a[4];
   logic [31:0]  exp_d[4];

   initial begin
      reset = 1'b1;
      req_valid = 0; req_write = 0; req_vector = 0; req_addr = 0; req_wdata = 0;
      dm_readdata = 0; dm_waitrequest = 0;
      repeat (2) @(negedge clk);
      #2 reset = 1'b0;

      // Reset / idle state
      step(1'b0);
      chk("rst_rdata", rdata, 128'h0);
      chk("rst_rvalid", rdata_valid, 1'b0);
      chk("rst_stall", stall_all, 1'b0);
      chk("rst_strobes", {dm_read, dm_write}, 2'b00);
      chk("byteen", dm_byteenable, 4'hF);

      // 1: scalar load 0x100
      s_valid = 1; s_write = 0; s_vector = 0; s_addr = 32'h100;
      step(1'b0);
      chk("sc_ld_read", dm_read, 1'b1);
      chk("sc_ld_addr", dm_addr, 32'h100);
      chk("sc_ld_stall", stall_all, 1'b0);
      chk("sc_ld_rdata", rdata, 128'hDEADBEEF);
      chk("sc_ld_rvalid", rdata_valid, 1'b1);
      // scalar load held off by waitrequest, unaligned address
      s_addr = 32'h103;
      step(1'b1);
      chk("sc_wr_addr", dm_addr, 32'h100);
      chk("sc_wr_stall", stall_all, 1'b1);
      chk("sc_wr_rvalid", rdata_valid, 1'b0);
      s_valid = 0;
      step(1'b0);
      chk("sc_idle_read", dm_read, 1'b0);

      // 2: vector store at 0x200
      run_vec(1'b1, 32'h200, 128'h44444444_33333333_22222222_11111111, -1, 0, st_n, dn_n, rd, rv);
      chk("vst_stall_n", st_n, 4);
      chk("vst_done_n", dn_n, 5);
      chk("vst_rvalid", rv, 1'b0);
      chk("vst_n", wlog.size(), 4);
      exp_a = '{32'h200, 32'h204, 32'h208, 32'h20C};
      exp_d = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444};
      for (int k = 0; k < 4; k++) if (k < wlog.size()) begin
         chk($sformatf("vst_addr%0d", k), wlog[k].addr, exp_a[k]);
         chk($sformatf("vst_data%0d", k), wlog[k].data, exp_d[k]);
      end

      // 3: vector load at 0x300, mem = 1,2,3,4
      run_vec(1'b0, 32'h300, 128'h0, -1, 0, st_n, dn_n, rd, rv);
      chk("vld_stall_n", st_n, 6);
      chk("vld_done_n", dn_n, 7);
      chk("vld_rdata", rd, 128'h00000004_00000003_00000002_00000001);
      chk("vld_rvalid", rv, 1'b1);
      step(1'b0);
      chk("vld_hold", rdata, 128'h00000004_00000003_00000002_00000001);
      chk("vld_rvalid_1cyc", rdata_valid, 1'b0);

      // 4: vector load, waitrequest on beat 1 for 3 cycles
      salt = 32'h10;
      run_vec(1'b0, 32'h300, 128'h0, 1, 3, st_n, dn_n, rd, rv);
      cnt = 0;
      foreach (alog[i]) if (alog[i] == 32'h304) cnt++;
      chk("vwr_addr304_n", cnt, 4);
      chk("vwr_stall_n", st_n, 9);
      chk("vwr_rdata", rd, 128'h00000014_00000013_00000012_00000011);
      chk("vwr_rvalid", rv, 1'b1);

      // 5: vector store wrapping past 2^32
      run_vec(1'b1, 32'hFFFF_FFF8, 128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA, -1, 0, st_n, dn_n, rd, rv);
      chk("vwrap_n", wlog.size(), 4);
      exp_a = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0, 32'h4};
      exp_d = '{32'hAAAAAAAA, 32'hBBBBBBBB, 32'hCCCCCCCC, 32'hDDDDDDDD};
      for (int k = 0; k < 4; k++) if (k < wlog.size()) begin
         chk($sformatf("vwrap_addr%0d", k), wlog[k].addr, exp_a[k]);
         chk($sformatf("vwrap_data%0d", k), wlog[k].data, exp_d[k]);
      end
`ifdef VSEQ_PERF_CNT_EN
      chk("perf_ops", perf_vec_ops, 32'd4);
`else
      chk("perf_ops_off", perf_vec_ops, 32'd0);
      chk("perf_stall_off", perf_stall_cyc, 32'd0);
`endif

      // 6: reset during beat 2 of a vector load
      s_valid = 1; s_write = 0; s_vector = 1; s_addr = 32'h300;
      step(1'b0);
      step(1'b0);
      step(1'b0);
      step(1'b0);
      chk("rst6_pre_addr", dm_addr, 32'h308);
      chk("rst6_pre_read", dm_read, 1'b1);
      s_valid = 0; s_vector = 0;
      req_valid = 1'b0; req_vector = 1'b0;
      reset = 1'b1;
      #1;
      chk("rst6_read", dm_read, 1'b0);
      chk("rst6_stall", stall_all, 1'b0);
      chk("rst6_rdata", rdata, 128'h0);
      chk("rst6_perf", {perf_vec_ops, perf_stall_cyc}, 64'h0);
      rdq.delete();
      step(1'b0);
      reset = 1'b0;
      step(1'b0);
      chk("rst6_idle_read", dm_read, 1'b0);
      chk("rst6_idle_stall", stall_all, 1'b0);

      // scalar store passthrough after reset
      s_valid = 1; s_write = 1; s_vector = 0; s_addr = 32'h40; s_wdata = 128'h0000CAFE;
      step(1'b0);
      chk("sc_st_write", {dm_write, dm_read}, 2'b10);
      chk("sc_st_data", dm_writedata, 32'h0000CAFE);
      chk("sc_st_rvalid", rdata_valid, 1'b0);
      s_valid = 0;
      step(1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end
endmodule
